syn_sram_arb: RTL and testbench
===============================

Name: syn_sram_arb

Overview:
- Two-requester arbiter in front of the SRAM memory driver inside VCORTEX. It shares the single SRAM access port between the VGA driver (pixel fetch) and the GPU (pixel draw).
- VGA has priority to protect the line buffer. A starvation limiter guarantees GPU forward progress.
- An in-order owner-tag FIFO routes read data returned by the driver back to whichever requester issued the read.

Parameters:
- ADDR_W, 18, SRAM word address width (256K x 16 part).
- DATA_W, 16, SRAM data width.
- RD_Q_DEPTH, 8, max outstanding reads (power of 2, >=2).
- GPU_STARVE_MAX, 4, consecutive VGA grants allowed while GPU waits before the GPU is forced through.

Ports:
- clk_ir  in  1  Clock. Single clock domain.
- rst_sync_l  in  1  Reset, asynchronous, active-low.
- vga_req  in  1  VGA request. Held with vga_we, vga_addr and vga_wdata stable until vga_ack.
- vga_we  in  1  1 = write, 0 = read.
- vga_addr  in  ADDR_W  Word address.
- vga_wdata  in  DATA_W  Write data.
- vga_ack  out  1  Request accepted this cycle.
- vga_rd_valid  out  1  Read data valid for VGA.
- vga_rdata  out  DATA_W  Read data.
- gpu_req, gpu_we, gpu_addr, gpu_wdata, gpu_ack, gpu_rd_valid, gpu_rdata: same as the VGA set, for the GPU.
- sram_req  out  1  Request to the driver.
- sram_we  out  1  Forwarded write enable.
- sram_addr  out  ADDR_W  Forwarded address.
- sram_wdata  out  DATA_W  Forwarded write data.
- sram_rdy  in  1  Driver accepts when sram_req & sram_rdy.
- sram_rd_valid  in  1  Driver read return, in issue order.
- sram_rdata  in  DATA_W  Driver read data.
- rd_outstanding  out  log2(RD_Q_DEPTH)+1  Current read-tag FIFO occupancy.
- rd_err  out  1  Sticky error flag: read return arrived with no tag queued.

Behaviour:
- Eligibility:
  - A requester is eligible when its req=1.
  - A pending read (we=0) is ineligible while the tag FIFO is full. Writes stay eligible when the FIFO is full.
- Grant, combinational each cycle:
  - If starve_cnt==GPU_STARVE_MAX and GPU is eligible, grant GPU.
  - Otherwise, if VGA is eligible, grant VGA.
  - Otherwise, if GPU is eligible, grant GPU.
  - Otherwise no grant.
- SRAM port drive:
  - sram_req=1 iff there is a grant.
  - sram_we, sram_addr and sram_wdata are muxed from the granted requester. They are 0 when there is no grant.
- Acknowledge: xxx_ack = grant_xxx & sram_rdy. Combinational; at most one ack per cycle. Zero-latency acceptance.
- starve_cnt (registered, 0..GPU_STARVE_MAX):
  - Increments (saturating) on vga_ack while the GPU is eligible and not granted.
  - Clears on gpu_ack, or when gpu_req=0.
  - Otherwise holds.
- Tag FIFO (registered, depth RD_Q_DEPTH, 1-bit owner, 0=VGA, 1=GPU):
  - Push the owner on each accepted read.
  - Pop on sram_rd_valid.
  - Simultaneous push and pop: occupancy unchanged, both take effect. This is allowed when full.
  - rd_outstanding = occupancy. Pointers wrap modulo RD_Q_DEPTH.
- Read return, registered, 1-cycle latency after sram_rd_valid:
  - vga_rd_valid <= sram_rd_valid & head==0.
  - gpu_rd_valid <= sram_rd_valid & head==1.
  - vga_rdata and gpu_rdata both <= sram_rdata when sram_rd_valid=1. Both hold otherwise.
  - Exactly one rd_valid per driver return.
- Underflow: sram_rd_valid with FIFO empty means no pop, no rd_valid, and rd_err <= 1. rd_err clears only on reset.
- Writes push no tag and produce no return.
- Reset (async, immediate):
  - starve_cnt=0, FIFO empty, rd_outstanding=0.
  - vga_rd_valid=gpu_rd_valid=0, rdata=0, rd_err=0.
  - Grant outputs follow the inputs combinationally. When req=0, sram_req=0.
  - Reset mid-operation discards all queued tags. Later driver returns flag rd_err unless the driver is reset together with this block; the system resets both.
- req dropped before ack: permitted. Nothing is issued and there is no side effect.

Test Plan:
- Single VGA read at addr 0x00010, sram_rdy=1, driver returns 0xBEEF 3 cycles later:
  - vga_ack in cycle 0.
  - vga_rd_valid=1 with vga_rdata=0xBEEF one cycle after sram_rd_valid.
  - gpu_rd_valid stays 0 throughout.
- VGA and GPU both requesting reads continuously, sram_rdy=1:
  - Grant pattern is 4 VGA acks, then 1 GPU ack, repeating.
  - starve_cnt cycles 0..4.
  - Returns are routed to the matching owner in issue order.
- Issue 8 reads with no driver return:
  - rd_outstanding=8.
  - A 9th read is held off (ack=0), while a concurrent GPU write is acked.
  - In the cycle a return arrives with a new read pending: pop and push occur together, the read is acked, and occupancy stays 8.
- sram_rdy=0 for 5 cycles with both requesting:
  - sram_req=1 with VGA fields driven.
  - No acks and starve_cnt unchanged.
  - The cycle sram_rdy rises: vga_ack=1.
- Spurious sram_rd_valid with an empty FIFO:
  - rd_err=1 and no rd_valid.
  - Assert rst_sync_l=0 with 3 reads outstanding: rd_outstanding=0 and rd_err=0 immediately.

Source files
------------

// File: rtl/syn_sram_arb.sv
// rtl/syn_sram_arb.sv - VGA/GPU arbiter for the shared SRAM driver port, with read-owner routing
// VGA wins by default; a starvation counter forces the GPU through after GPU_STARVE_MAX VGA grants.
module syn_sram_arb #(
   parameter int ADDR_W         = 18,
   parameter int DATA_W         = 16,
   parameter int RD_Q_DEPTH     = 8,
   parameter int GPU_STARVE_MAX = 4
) (
   input  logic                          clk_ir,
   input  logic                          rst_sync_l,
   input  logic                          vga_req,
   input  logic                          vga_we,
   input  logic [ADDR_W-1:0]             vga_addr,
   input  logic [DATA_W-1:0]             vga_wdata,
   output logic                          vga_ack,
   output logic                          vga_rd_valid,
   output logic [DATA_W-1:0]             vga_rdata,
   input  logic                          gpu_req,
   input  logic                          gpu_we,
   input  logic [ADDR_W-1:0]             gpu_addr,
   input  logic [DATA_W-1:0]             gpu_wdata,
   output logic                          gpu_ack,
   output logic                          gpu_rd_valid,
   output logic [DATA_W-1:0]             gpu_rdata,
   output logic                          sram_req,
   output logic                          sram_we,
   output logic [ADDR_W-1:0]             sram_addr,
   output logic [DATA_W-1:0]             sram_wdata,
   input  logic                          sram_rdy,
   input  logic                          sram_rd_valid,
   input  logic [DATA_W-1:0]             sram_rdata,
   output logic [$clog2(RD_Q_DEPTH):0]   rd_outstanding,
   output logic                          rd_err
);

   localparam int PTR_W = $clog2(RD_Q_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ST_W  = $clog2(GPU_STARVE_MAX + 1);

   logic [RD_Q_DEPTH-1:0] tag_q, tag_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      occ_q, occ_d;
   logic [ST_W-1:0]       starve_q, starve_d;
   logic                  vga_rd_valid_q, vga_rd_valid_d;
   logic                  gpu_rd_valid_q, gpu_rd_valid_d;
   logic [DATA_W-1:0]     rdata_q, rdata_d;
   logic                  rd_err_q, rd_err_d;

   logic fifo_full, fifo_empty, pop, push, room;
   logic vga_elig, gpu_elig, grant_vga, grant_gpu, head;

   assign fifo_full  = (occ_q == CNT_W'(RD_Q_DEPTH));
   assign fifo_empty = (occ_q == '0);
   assign pop        = sram_rd_valid & ~fifo_empty;
   // A return in the same cycle frees a slot, so a read may still be accepted when full.
   assign room       = ~fifo_full | pop;
   assign vga_elig   = vga_req & (vga_we | room);
   assign gpu_elig   = gpu_req & (gpu_we | room);
   assign grant_gpu  = gpu_elig & ((starve_q == ST_W'(GPU_STARVE_MAX)) | ~vga_elig);
   assign grant_vga  = vga_elig & ~grant_gpu;

   assign vga_ack    = grant_vga & sram_rdy;
   assign gpu_ack    = grant_gpu & sram_rdy;
   assign sram_req   = grant_vga | grant_gpu;
   assign sram_we    = (grant_vga & vga_we) | (grant_gpu & gpu_we);
   assign sram_addr  = ({ADDR_W{grant_vga}} & vga_addr) | ({ADDR_W{grant_gpu}} & gpu_addr);
   assign sram_wdata = ({DATA_W{grant_vga}} & vga_wdata) | ({DATA_W{grant_gpu}} & gpu_wdata);

   assign push       = (vga_ack & ~vga_we) | (gpu_ack & ~gpu_we);
   assign head       = tag_q[rd_ptr_q];

   always_comb begin
      tag_d    = tag_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         tag_d[wr_ptr_q] = gpu_ack;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      occ_d = occ_q + CNT_W'(push) - CNT_W'(pop);

      starve_d = starve_q;
      if (gpu_ack || !gpu_req) begin
         starve_d = '0;
      end else if (vga_ack && gpu_elig && (starve_q != ST_W'(GPU_STARVE_MAX))) begin
         starve_d = starve_q + ST_W'(1);
      end

      vga_rd_valid_d = pop & ~head;
      gpu_rd_valid_d = pop & head;
      rdata_d        = sram_rd_valid ? sram_rdata : rdata_q;
      rd_err_d       = rd_err_q | (sram_rd_valid & fifo_empty);
   end

   always_ff @(posedge clk_ir or negedge rst_sync_l) begin
      if (!rst_sync_l) begin
         tag_q          <= '0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         occ_q          <= '0;
         starve_q       <= '0;
         vga_rd_valid_q <= 1'b0;
         gpu_rd_valid_q <= 1'b0;
         rdata_q        <= '0;
         rd_err_q       <= 1'b0;
      end else begin
         tag_q          <= tag_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         occ_q          <= occ_d;
         starve_q       <= starve_d;
         vga_rd_valid_q <= vga_rd_valid_d;
         gpu_rd_valid_q <= gpu_rd_valid_d;
         rdata_q        <= rdata_d;
         rd_err_q       <= rd_err_d;
      end
   end

   assign vga_rd_valid   = vga_rd_valid_q;
   assign gpu_rd_valid   = gpu_rd_valid_q;
   assign vga_rdata      = rdata_q;
   assign gpu_rdata      = rdata_q;
   assign rd_outstanding = occ_q;
   assign rd_err         = rd_err_q;

endmodule

// File: tb/tb_syn_sram_arb.sv
// tb/tb_syn_sram_arb.sv - directed bench for syn_sram_arb with a driver model and read scoreboard
module tb_syn_sram_arb;

   localparam int LAT = 3;

   logic        clk_ir = 1'b0;
   logic        rst_sync_l;
   logic        vga_req, vga_we, gpu_req, gpu_we;
   logic [17:0] vga_addr, gpu_addr;
   logic [15:0] vga_wdata, gpu_wdata;
   logic        vga_ack, gpu_ack, vga_rd_valid, gpu_rd_valid;
   logic [15:0] vga_rdata, gpu_rdata;
   logic        sram_req, sram_we, sram_rdy, sram_rd_valid;
   logic [17:0] sram_addr;
   logic [15:0] sram_wdata, sram_rdata;
   logic [3:0]  rd_outstanding;
   logic        rd_err;

   syn_sram_arb dut (
      .clk_ir(clk_ir), .rst_sync_l(rst_sync_l),
      .vga_req(vga_req), .vga_we(vga_we), .vga_addr(vga_addr), .vga_wdata(vga_wdata),
      .vga_ack(vga_ack), .vga_rd_valid(vga_rd_valid), .vga_rdata(vga_rdata),
      .gpu_req(gpu_req), .gpu_we(gpu_we), .gpu_addr(gpu_addr), .gpu_wdata(gpu_wdata),
      .gpu_ack(gpu_ack), .gpu_rd_valid(gpu_rd_valid), .gpu_rdata(gpu_rdata),
      .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
      .sram_rdy(sram_rdy), .sram_rd_valid(sram_rd_valid), .sram_rdata(sram_rdata),
      .rd_outstanding(rd_outstanding), .rd_err(rd_err)
   );

   always #5 clk_ir = ~clk_ir;

   typedef struct { int due; logic [15:0] data; } drv_t;
   typedef struct { logic owner; logic [15:0] data; } exp_t;
   drv_t drv_q[$];
   exp_t exp_q[$];

   int   n_checks = 0;
   int   n_err    = 0;
   int   cyc_n    = 0;
   logic drv_en   = 1'b1;
   logic spur     = 1'b0;
   logic ret_now  = 1'b0;
   logic ret_prev = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Driver model returns read data (addr ^ 0xBEFF) LAT cycles after acceptance, in order.
   task automatic settle();
      exp_t e;
      ret_now       = 1'b0;
      sram_rd_valid = 1'b0;
      if (spur) begin
         sram_rd_valid = 1'b1;
         sram_rdata    = 16'hDEAD;
      end else if (drv_en && drv_q.size() > 0 && drv_q[0].due <= cyc_n) begin
         sram_rd_valid = 1'b1;
         sram_rdata    = drv_q[0].data;
         void'(drv_q.pop_front());
         ret_now = 1'b1;
      end
      #1;
      if (ret_prev) begin
         if (exp_q.size() == 0) begin
            chk("scoreboard_underrun", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("ret_vga_valid", vga_rd_valid, !e.owner);
            chk("ret_gpu_valid", gpu_rd_valid, e.owner);
            chk("ret_rdata", e.owner ? gpu_rdata : vga_rdata, e.data);
         end
      end else begin
         chk("idle_vga_valid", vga_rd_valid, 0);
         chk("idle_gpu_valid", gpu_rd_valid, 0);
      end
      if (vga_ack && !vga_we) begin
         drv_q.push_back('{cyc_n + LAT, vga_addr[15:0] ^ 16'hBEFF});
         exp_q.push_back('{1'b0, vga_addr[15:0] ^ 16'hBEFF});
      end
      if (gpu_ack && !gpu_we) begin
         drv_q.push_back('{cyc_n + LAT, gpu_addr[15:0] ^ 16'hBEFF});
         exp_q.push_back('{1'b1, gpu_addr[15:0] ^ 16'hBEFF});
      end
   endtask

   task automatic adv();
      ret_prev = ret_now;
      @(posedge clk_ir);
      #1;
      cyc_n++;
   endtask

   initial begin
      logic [17:0] va, ga;
      logic [2:0]  st0;
      rst_sync_l = 1'b0;
      vga_req = 0; vga_we = 0; vga_addr = 0; vga_wdata = 0;
      gpu_req = 0; gpu_we = 0; gpu_addr = 0; gpu_wdata = 0;
      sram_rdy = 1'b1; sram_rd_valid = 1'b0; sram_rdata = 0;
      repeat (2) @(posedge clk_ir);
      #1;
      chk("rst_outstanding", rd_outstanding, 0);
      chk("rst_rd_err", rd_err, 0);
      chk("rst_vga_valid", vga_rd_valid, 0);
      chk("rst_gpu_valid", gpu_rd_valid, 0);
      chk("rst_rdata", vga_rdata, 0);
      chk("rst_sram_req", sram_req, 0);
      chk("rst_sram_addr", sram_addr, 0);
      rst_sync_l = 1'b1;

      // single VGA read
      vga_req = 1; vga_we = 0; vga_addr = 18'h00010;
      settle();
      chk("t1_vga_ack", vga_ack, 1);
      chk("t1_sram_addr", sram_addr, 18'h00010);
      chk("t1_sram_we", sram_we, 0);
      adv();
      vga_req = 0;
      for (int i = 0; i < 4; i++) begin
         settle();
         if (i == 3) begin
            chk("t1_vga_rd_valid", vga_rd_valid, 1);
            chk("t1_vga_rdata", vga_rdata, 16'hBEEF);
         end
         chk("t1_gpu_rd_valid", gpu_rd_valid, 0);
         adv();
      end

      // both reading continuously: 4 VGA then 1 GPU
      va = 18'h00100; ga = 18'h00200;
      vga_req = 1; vga_we = 0; gpu_req = 1; gpu_we = 0;
      for (int k = 0; k < 15; k++) begin
         vga_addr = va; gpu_addr = ga;
         settle();
         chk("rr_starve", dut.starve_q, k % 5);
         chk("rr_gpu_ack", gpu_ack, (k % 5) == 4);
         chk("rr_vga_ack", vga_ack, (k % 5) != 4);
         if (vga_ack) va++;
         if (gpu_ack) ga++;
         adv();
      end
      vga_req = 0; gpu_req = 0;
      repeat (6) begin settle(); adv(); end
      chk("rr_drained", rd_outstanding, 0);

      // fill the tag FIFO with no returns
      drv_en = 0;
      va = 18'h01000;
      vga_req = 1; vga_we = 0;
      for (int i = 0; i < 8; i++) begin
         vga_addr = va;
         settle();
         chk("fill_vga_ack", vga_ack, 1);
         va++;
         adv();
      end
      vga_addr = va;
      gpu_req = 1; gpu_we = 1; gpu_addr = 18'h02222; gpu_wdata = 16'h1357;
      settle();
      chk("full_outstanding", rd_outstanding, 8);
      chk("full_vga_held", vga_ack, 0);
      chk("full_gpu_wr_ack", gpu_ack, 1);
      chk("full_sram_we", sram_we, 1);
      chk("full_sram_wdata", sram_wdata, 16'h1357);
      adv();
      gpu_req = 0; gpu_we = 0;
      drv_en = 1;
      settle();
      chk("full_swap_ack", vga_ack, 1);
      adv();
      vga_req = 0;
      settle();
      chk("full_swap_occ", rd_outstanding, 8);
      adv();
      repeat (14) begin settle(); adv(); end
      chk("full_drained", rd_outstanding, 0);

      // driver stalled with both requesting
      sram_rdy = 0;
      vga_req = 1; vga_we = 1; vga_addr = 18'h31234; vga_wdata = 16'hA55A;
      gpu_req = 1; gpu_we = 0; gpu_addr = 18'h2ABCD;
      settle();
      st0 = dut.starve_q;
      chk("stall_starve_start", st0, 0);
      adv();
      for (int i = 0; i < 5; i++) begin
         settle();
         chk("stall_sram_req", sram_req, 1);
         chk("stall_sram_we", sram_we, 1);
         chk("stall_sram_addr", sram_addr, 18'h31234);
         chk("stall_sram_wdata", sram_wdata, 16'hA55A);
         chk("stall_no_vga_ack", vga_ack, 0);
         chk("stall_no_gpu_ack", gpu_ack, 0);
         chk("stall_starve", dut.starve_q, 0);
         adv();
      end
      sram_rdy = 1;
      settle();
      chk("stall_release_vga_ack", vga_ack, 1);
      chk("stall_release_gpu_ack", gpu_ack, 0);
      adv();
      vga_req = 0; vga_we = 0;
      settle();
      chk("stall_starve_after", dut.starve_q, 1);
      chk("stall_gpu_ack", gpu_ack, 1);
      adv();
      gpu_req = 0;
      repeat (6) begin settle(); adv(); end
      chk("stall_drained", rd_outstanding, 0);

      // spurious return with empty FIFO
      spur = 1;
      settle();
      adv();
      spur = 0;
      settle();
      chk("spur_rd_err", rd_err, 1);
      chk("spur_occ", rd_outstanding, 0);
      adv();
      settle();
      chk("spur_rd_err_sticky", rd_err, 1);
      adv();

      // async reset with reads outstanding
      drv_en = 0;
      vga_req = 1; vga_we = 0;
      for (int i = 0; i < 3; i++) begin
         vga_addr = 18'h00400 + 18'(i);
         settle();
         adv();
      end
      vga_req = 0;
      settle();
      chk("pre_rst_occ", rd_outstanding, 3);
      rst_sync_l = 0;
      #1;
      chk("rst_mid_occ", rd_outstanding, 0);
      chk("rst_mid_rd_err", rd_err, 0);
      vga_req = 1; vga_we = 1;
      #1;
      chk("rst_mid_sram_req_on", sram_req, 1);
      vga_req = 0; vga_we = 0;
      #1;
      chk("rst_mid_sram_req_off", sram_req, 0);
      drv_q.delete();
      exp_q.delete();
      ret_now = 0;
      ret_prev = 0;
      @(posedge clk_ir);
      #1;
      cyc_n++;
      rst_sync_l = 1;
      drv_en = 1;
      settle();
      chk("post_rst_occ", rd_outstanding, 0);
      adv();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
